// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control opcodes and execute-stage FSM encoding.
// The upstream ALU control decoder imports the same constants.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_MUL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_XOR = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation-in / result-out handshake bundle between producer, execute unit and consumer.
interface alu_exec_unit_if #(
   parameter int DATA_W = 32
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [3:0]        ALU_Ctrl_i;
   logic [DATA_W-1:0] src1_i;
   logic [DATA_W-1:0] src2_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] result_o;
   logic              zero_o;
   logic              illegal_o;

   modport slave (
      input  in_valid_i, ALU_Ctrl_i, src1_i, src2_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
   );

   modport master (
      output in_valid_i, ALU_Ctrl_i, src1_i, src2_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low DATA_W bits; always runs exactly DATA_W steps.
// prod_o is the accumulator value being written this cycle, valid when done_o is high.
module alu_mul_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] prod_o
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         acc_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         cnt_d    = CNT_W'(DATA_W);
      end else if (cnt_q != '0) begin
         acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));
   assign prod_o = acc_d;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arith ops, iterative MUL, registered result over valid/ready.
//   state   | meaning
//   IDLE    | ready for a new operation
//   MUL     | shift-add multiply in progress, producer stalled
//   DONE    | result presented, held until consumer takes it
module alu_exec_unit
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   alu_exec_unit_if.slave  bus
);
   alu_state_e        state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic              illegal_q, illegal_d;

   logic [DATA_W-1:0] op_res;
   logic              op_illegal;
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] mul_prod;

   alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (mul_start),
      .a_i     (bus.src1_i),
      .b_i     (bus.src2_i),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   always_comb begin
      op_res     = '0;
      op_illegal = 1'b0;
      case (bus.ALU_Ctrl_i)
         ALU_AND: op_res = bus.src1_i & bus.src2_i;
         ALU_OR:  op_res = bus.src1_i | bus.src2_i;
         ALU_ADD: op_res = bus.src1_i + bus.src2_i;
         ALU_SUB: op_res = bus.src1_i - bus.src2_i;
         ALU_XOR: op_res = bus.src1_i ^ bus.src2_i;
         ALU_SLT: op_res = ($signed(bus.src1_i) < $signed(bus.src2_i)) ?
                           {{(DATA_W-1){1'b0}}, 1'b1} : '0;
         ALU_MUL: op_res = '0;
         default: op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid_i) begin
               if (bus.ALU_Ctrl_i == ALU_MUL) begin
                  mul_start = 1'b1;
                  state_d   = ST_MUL;
               end else begin
                  result_d  = op_res;
                  zero_d    = (op_res == '0);
                  illegal_d = op_illegal;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               result_d  = mul_prod;
               zero_d    = (mul_prod == '0);
               illegal_d = 1'b0;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.in_ready_o  = (state_q == ST_IDLE);
   assign bus.out_valid_o = (state_q == ST_DONE);
   assign bus.result_o    = result_q;
   assign bus.zero_o      = zero_q;
   assign bus.illegal_o   = illegal_q;

endmodule
